alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU between two requesters:
  - requester 0: fetch/PC-increment path.
  - requester 1: execute path.
- Valid/ready request handshake; round-robin arbitration on contention.
- Drives the existing alu instance and returns a registered, tagged result one cycle after acceptance.
- Sits between the datapath control and alu; replaces direct hard-wiring of alu_op and operands.

Parameters:
- OPW, `ALU_OP_LENGTH: width of the op field (from head.v).
- CNTW, 16: width of the saturating contention counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  pipeline enable; 0 = stall, no grants, all state held.
- req0_valid  input  1  requester 0 has an operation.
- req0_op  input  OPW  ALU operation for requester 0.
- req0_a  input  32  SrcA for requester 0.
- req0_b  input  32  SrcB for requester 0.
- req0_ready  output  1  requester 0 granted this cycle (combinational).
- req1_valid  input  1  requester 1 has an operation.
- req1_op  input  OPW  ALU operation for requester 1.
- req1_a  input  32  SrcA for requester 1.
- req1_b  input  32  SrcB for requester 1.
- req1_ready  output  1  requester 1 granted this cycle (combinational).
- rsp_valid  output  1  result valid, one-cycle pulse.
- rsp_id  output  1  requester that owns rsp_data.
- rsp_data  output  32  registered ALU result.
- conflict_cnt  output  CNTW  cycles with both requests valid while en=1, saturating.

Behaviour:
- Transfer on reqN_valid && reqN_ready. At most one transfer per cycle.
- Requester must hold op/a/b stable while valid && !ready. The arbiter does not check this.
- Grant, combinational, gated by en && rst_n:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester indicated by prio is granted.
  - Neither valid: no grant; ALU operands are don't-care.
- prio register:
  - Reset value 0.
  - After any transfer, prio <= ~winner. The requester that just won has lower priority next cycle.
  - Unchanged when there is no transfer.
- Starvation bound: under continuous contention, grants strictly alternate 0,1,0,1…; each requester waits at most 1 cycle.
- Datapath:
  - The winner's op/a/b are muxed into alu.
  - ALUout is captured into rsp_data on the transfer edge.
- Latency: exactly 1 cycle. On the edge after a transfer:
  - rsp_valid=1, rsp_id=winner, rsp_data=result.
- Response hold rules:
  - rsp_valid is high for exactly one cycle per transfer.
  - Back-to-back transfers give consecutive rsp_valid cycles.
  - rsp_data and rsp_id hold their last values while rsp_valid=0.
  - There is no response backpressure.
- ALU arithmetic is 32-bit modulo: ADDU/SUBU wrap with no flags. Any op other than ADDU/SUBU/OR yields 0 (alu default); the arbiter still returns it as a normal response.
- en=0:
  - Both readies are 0.
  - rsp_valid goes 0 next edge.
  - prio and conflict_cnt hold.
  - Requesters stay valid and are served after en returns.
- conflict_cnt:
  - Increments on each edge where en && req0_valid && req1_valid.
  - Saturates at all-ones; never wraps.
- Reset (rst_n=0 at an edge), including mid-operation:
  - rsp_valid=0, rsp_id=0, rsp_data=0, prio=0, conflict_cnt=0.
  - Both readies are 0 while rst_n=0.
  - An operation accepted on the edge where reset is sampled is dropped; no response is produced.

Decomposition:
- head.v (shared constants):
  - `ALU_OP_ADDU/SUBU/OR and `ALU_OP_LENGTH stay there.
  - Add `ARB_ID_FETCH (1'b0) and `ARB_ID_EXEC (1'b1).
- Sub-module: one instance of the existing alu provides the arithmetic. No other sub-modules.
- Arbitration and registers are inline.

Test Plan:
- Single request: req0 ADDU a=5 b=7, req1 idle -> req0_ready=1 same cycle; next edge rsp_valid=1, rsp_id=0, rsp_data=12.
- Contention after reset, both valid:
  - Inputs: req0 SUBU 10,3 and req1 OR 0xF0,0x0F.
  - Cycle 1: grant 0 -> rsp 7 id 0.
  - Cycle 2: grant 1 -> rsp 0xFF id 1.
  - conflict_cnt=1.
- Continuous contention, 6 cycles -> grants alternate 0,1,0,1,0,1; no idle rsp cycle; conflict_cnt increments only while both valid.
- Wrap and invalid op: ADDU 0xFFFFFFFF,1 -> rsp_data=0; SUBU 0,1 -> 0xFFFFFFFF; undefined op code -> rsp_data=0 with rsp_valid=1.
- Stall and reset:
  - en=0 with both valid for 3 cycles -> readies 0, no rsp, prio/conflict_cnt held.
  - rst_n=0 on the edge of an accepted request -> no response; all outputs 0.
- Saturation: CNTW forced to 2, contention for 5 cycles -> conflict_cnt stops at 3.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the execute-stage ALU and its arbiter:
// ALU operation encodings, op-field width and requester identifiers.
package alu_arbiter_pkg;

    // Width of the ALU operation field.
    localparam int ALU_OP_LENGTH = 4;

    // ALU operation encodings; every other code makes the ALU return 0.
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_ADDU = 4'h0;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SUBU = 4'h1;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_OR   = 4'h2;

    // Requester identifiers, as carried on rsp_id.
    typedef enum logic {
        ARB_ID_FETCH = 1'b0,
        ARB_ID_EXEC  = 1'b1
    } arb_id_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Execute-stage ALU: purely combinational 32-bit unit.
// ADDU/SUBU wrap modulo 2^32 with no flags; unknown ops yield 0.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int OPW = ALU_OP_LENGTH
) (
    input  logic [OPW-1:0] alu_op,
    input  logic [31:0]    src_a,
    input  logic [31:0]    src_b,
    output logic [31:0]    alu_out
);

    // Operation decode; the default arm covers every undefined code.
    always_comb begin
        alu_out = 32'd0;
        case (alu_op)
            OPW'(ALU_OP_ADDU): alu_out = src_a + src_b;
            OPW'(ALU_OP_SUBU): alu_out = src_a - src_b;
            OPW'(ALU_OP_OR):   alu_out = src_a | src_b;
            default:           alu_out = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared execute-stage ALU.
// Requester 0 is the fetch/PC-increment path, requester 1 the execute
// path. Grants are combinational, contention is resolved round-robin
// via a one-bit priority register, and the ALU result comes back
// registered and tagged one cycle after the transfer.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int OPW  = ALU_OP_LENGTH,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            req0_valid,
    input  logic [OPW-1:0]  req0_op,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [OPW-1:0]  req1_op,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    output logic            req1_ready,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [31:0]     rsp_data,
    output logic [CNTW-1:0] conflict_cnt
);

    // prio_reg names the requester that wins the next contended cycle.
    logic            prio_reg;
    logic            rsp_valid_reg;
    logic            rsp_id_reg;
    logic [31:0]     rsp_data_reg;
    logic [CNTW-1:0] conflict_cnt_reg;

    logic            grant0;
    logic            grant1;
    logic            xfer;
    logic            contend;
    arb_id_e         winner;
    logic [OPW-1:0]  alu_op_sel;
    logic [31:0]     alu_a_sel;
    logic [31:0]     alu_b_sel;
    logic [31:0]     alu_result;

    // Grant decision: a lone requester always wins; under contention
    // prio_reg decides. Nothing is granted while stalled or in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (en && rst_n) begin
            if (req0_valid && req1_valid) begin
                grant0 = (prio_reg == ARB_ID_FETCH);
                grant1 = (prio_reg == ARB_ID_EXEC);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign winner     = grant1 ? ARB_ID_EXEC : ARB_ID_FETCH;
    assign contend    = en && req0_valid && req1_valid;

    // Operand mux into the ALU; requester 1 only when it holds the grant,
    // otherwise requester 0 (operands are don't-care with no grant).
    always_comb begin
        alu_op_sel = req0_op;
        alu_a_sel  = req0_a;
        alu_b_sel  = req0_b;
        if (grant1) begin
            alu_op_sel = req1_op;
            alu_a_sel  = req1_a;
            alu_b_sel  = req1_b;
        end
    end

    alu #(
        .OPW (OPW)
    ) u_alu (
        .alu_op  (alu_op_sel),
        .src_a   (alu_a_sel),
        .src_b   (alu_b_sel),
        .alu_out (alu_result)
    );

    // Response, priority and contention-counter registers. A stall keeps
    // everything except rsp_valid, which must fall so no pulse repeats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_reg         <= ARB_ID_FETCH;
            rsp_valid_reg    <= 1'b0;
            rsp_id_reg       <= ARB_ID_FETCH;
            rsp_data_reg     <= 32'd0;
            conflict_cnt_reg <= '0;
        end else if (en) begin
            rsp_valid_reg <= xfer;
            if (xfer) begin
                rsp_id_reg   <= winner;
                rsp_data_reg <= alu_result;
                prio_reg     <= ~winner;
            end
            if (contend && (conflict_cnt_reg != {CNTW{1'b1}})) begin
                conflict_cnt_reg <= conflict_cnt_reg + CNTW'(1);
            end
        end else begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid    = rsp_valid_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_data     = rsp_data_reg;
    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by a
// randomized phase, all compared against a behavioural model kept here.
// A second instance with a 2-bit counter shares the stimulus so that
// counter saturation is observable in a few cycles.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int OPW = ALU_OP_LENGTH;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic        req0_valid, req1_valid;
    logic [OPW-1:0] req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_data;
    logic [15:0] conflict_cnt;

    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
    logic [31:0] s_rsp_data;
    logic [1:0]  s_conflict_cnt;

    int passed = 0;
    int total  = 0;

    // Behavioural model state.
    int          m_last_winner;   // requester that won most recently (1 after reset)
    bit          m_rsp_valid;
    int          m_rsp_id;
    logic [31:0] m_rsp_data;
    int          m_cnt;
    int          m_cnt_small;

    always #5 clk = ~clk;

    alu_arbiter #(.OPW(OPW), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .conflict_cnt(conflict_cnt)
    );

    alu_arbiter #(.OPW(OPW), .CNTW(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(s_req1_ready),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
        .conflict_cnt(s_conflict_cnt)
    );

    // Reference ALU in plain modular arithmetic.
    function automatic logic [31:0] ref_alu(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned m = 64'h1_0000_0000;
        if (op == ALU_OP_ADDU) return 32'((64'(a) + 64'(b)) % m);
        if (op == ALU_OP_SUBU) return 32'((64'(a) + m - 64'(b)) % m);
        if (op == ALU_OP_OR)   return a | b;
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    // One clock cycle: drive inputs, check grants, predict the edge, check outputs.
    task automatic step(input bit v0, input logic [OPW-1:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [OPW-1:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit e, input bit r);
        int g;
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        en = e; rst_n = r;
        #1;
        g = -1;
        if (e && r) begin
            if (v0 && v1)  g = (m_last_winner == 1) ? 0 : 1;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
        @(posedge clk);
        if (!r) begin
            m_last_winner = 1; m_rsp_valid = 0; m_rsp_id = 0; m_rsp_data = 0;
            m_cnt = 0; m_cnt_small = 0;
        end else if (e) begin
            m_rsp_valid = (g >= 0);
            if (g >= 0) begin
                m_rsp_id      = g;
                m_rsp_data    = (g == 0) ? ref_alu(o0, a0, b0) : ref_alu(o1, a1, b1);
                m_last_winner = g;
            end
            if (v0 && v1) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_small < 3) m_cnt_small++;
            end
        end else begin
            m_rsp_valid = 0;
        end
        #1;
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp_valid});
        chk("rsp_id", {31'd0, rsp_id}, 32'(m_rsp_id));
        chk("rsp_data", rsp_data, m_rsp_data);
        chk("conflict_cnt", {16'd0, conflict_cnt}, 32'(m_cnt));
        chk("conflict_cnt_sat", {30'd0, s_conflict_cnt}, 32'(m_cnt_small));
        if (g >= 0)
            $display("xfer id=%0d op=%0d data=%h cnt=%0d", g, (g == 0) ? o0 : o1, m_rsp_data, m_cnt);
    endtask

    initial begin
        logic [OPW-1:0] bad_op;
        bad_op = 4'hB;
        m_last_winner = 1; m_rsp_valid = 0; m_rsp_id = 0; m_rsp_data = 0;
        m_cnt = 0; m_cnt_small = 0;
        rst_n = 0; en = 1;
        req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;

        // Reset with requests pending: no grants, outputs cleared.
        step(1, ALU_OP_ADDU, 1, 2, 1, ALU_OP_OR, 3, 4, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Single request, then idle cycle (response must hold).
        step(1, ALU_OP_ADDU, 5, 7, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Contention after a fresh reset.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, ALU_OP_SUBU, 10, 3, 1, ALU_OP_OR, 32'hF0, 32'h0F, 1, 1);
        step(0, 0, 0, 0, 1, ALU_OP_OR, 32'hF0, 32'h0F, 1, 1);

        // Continuous contention for six cycles.
        for (int i = 0; i < 6; i++)
            step(1, ALU_OP_ADDU, $urandom, $urandom, 1, ALU_OP_SUBU, $urandom, $urandom, 1, 1);

        // Wrap-around and undefined op.
        step(1, ALU_OP_ADDU, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, ALU_OP_SUBU, 0, 1, 1, 1);
        step(1, bad_op, 32'h1234, 32'h5678, 0, 0, 0, 0, 1, 1);

        // Stall with both valid, then resume.
        for (int i = 0; i < 3; i++)
            step(1, ALU_OP_OR, 32'hA0, 32'h05, 1, ALU_OP_ADDU, 9, 9, 0, 1);
        step(1, ALU_OP_OR, 32'hA0, 32'h05, 1, ALU_OP_ADDU, 9, 9, 1, 1);
        step(1, ALU_OP_OR, 32'hA0, 32'h05, 1, ALU_OP_ADDU, 9, 9, 1, 1);

        // Reset sampled while a request is presented: dropped.
        step(1, ALU_OP_ADDU, 40, 2, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Saturation of the 2-bit counter instance.
        for (int i = 0; i < 5; i++)
            step(1, ALU_OP_ADDU, i, 1, 1, ALU_OP_OR, i, 2, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a0, b0, a1, b1;
            a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b0 = ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom;
            a1 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            b1 = $urandom;
            step($urandom_range(0, 9) < 7, OPW'($urandom_range(0, 5)), a0, b0,
                 $urandom_range(0, 9) < 7, OPW'($urandom_range(0, 5)), a1, b1,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 49) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
